// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: issues one word address per cycle for the missing block,
// then steers returning words into the data array and writes the tag with the last word.
module cache_fill_fsm #(
  parameter int ADDR_W          = 16,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              mem_read,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic [2:0]        word_index
);

  localparam int CNT_W = $clog2(WORDS_PER_BLOCK + 1);
  localparam logic [CNT_W-1:0] WORDS_C = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(2 * WORDS_PER_BLOCK - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  recv_cnt;
  logic [ADDR_W-1:0] base;
  logic              issuing;
  logic              word_write;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      base      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_detected) begin
            base      <= miss_address & ~OFF_MASK;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            state     <= FILL;
          end
        end
        FILL: begin
          // Issue and return sides advance independently; returns may overlap issue.
          if (issue_cnt < WORDS_C)
            issue_cnt <= issue_cnt + 1'b1;
          if (memory_data_valid) begin
            recv_cnt <= recv_cnt + 1'b1;
            if (recv_cnt == LAST_C) begin
              state     <= IDLE;
              issue_cnt <= '0;
              recv_cnt  <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign issuing  = (state == FILL) && (issue_cnt < WORDS_C);
  assign fsm_busy = (state == FILL);
  assign mem_read = issuing;

  // base is block-aligned, so the word offset never carries past the block.
  assign memory_address = issuing ? (base | ADDR_W'({issue_cnt, 1'b0})) : '0;

  // Gated by rst_n so a reset edge never coincides with an array or tag write.
  assign word_write       = rst_n && (state == FILL) && memory_data_valid;
  assign write_data_array = word_write;
  assign write_tag_array  = word_write && (recv_cnt == LAST_C);
  assign word_index       = (state == FILL) ? recv_cnt[2:0] : 3'd0;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: a latency/gap memory model feeds returns, and
// each fill is checked against the block's expected address list and word order.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = 16'h0;
  logic        memory_data_valid = 1'b0;
  logic        fsm_busy, mem_read, write_data_array, write_tag_array;
  logic [15:0] memory_address;
  logic [2:0]  word_index;

  cache_fill_fsm #(.ADDR_W(16), .WORDS_PER_BLOCK(8)) dut (
    .clk(clk), .rst_n(rst_n), .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_data_valid(memory_data_valid), .fsm_busy(fsm_busy), .mem_read(mem_read),
    .memory_address(memory_address), .write_data_array(write_data_array),
    .write_tag_array(write_tag_array), .word_index(word_index)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   due_q[$];
  int   last_due = 0;
  int   gap_fixed = 0;
  int   gap_rand = 0;
  logic cur_vld;

  // One cycle: drive inputs after the falling edge, let outputs settle, run the memory model.
  task automatic tick(input logic miss, input logic [15:0] addr, input logic extra_vld);
    int d;
    @(negedge clk);
    cyc++;
    cur_vld = extra_vld;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      void'(due_q.pop_front());
      cur_vld = 1'b1;
    end
    miss_detected     = miss;
    miss_address      = addr;
    memory_data_valid = cur_vld;
    #2;
    if (mem_read === 1'b1) begin
      d = cyc + 4;
      if (d < last_due + 1 + gap_fixed) d = last_due + 1 + gap_fixed;
      if (gap_rand > 0) d += $urandom_range(gap_rand);
      due_q.push_back(d);
      last_due = d;
    end
  endtask

  // One whole fill of the block containing addr. inj_at: fill cycle with a stray miss to
  // 0x4000 (0 = none). rst_after: pull reset once that many words are written (0 = never).
  task automatic run_fill(input logic [15:0] addr, input int inj_at, input int rst_after);
    logic [15:0] base;
    logic [15:0] exp_addr;
    logic        exp_rd;
    int          nw;
    bit          done;
    base = addr & 16'hFFF0;
    nw   = 0;
    done = 0;
    due_q.delete();
    tick(1'b1, addr, 1'b0);
    n_tests++;
    if (fsm_busy !== 1'b0 || mem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL miss_cycle addr=%h: busy=%b mem_read=%b, want 0 0", addr, fsm_busy, mem_read);
    end
    for (int k = 1; k <= 60 && !done; k++) begin
      if (rst_after > 0 && nw == rst_after) rst_n = 1'b0;
      tick(k == inj_at, 16'h4000, 1'b0);
      if (rst_n === 1'b0) begin
        n_tests++;
        if (write_data_array !== 1'b0 || write_tag_array !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_edge_write: wr=%b tag=%b, want 0 0", write_data_array, write_tag_array);
        end
        done = 1;
      end else begin
        exp_rd   = (k <= 8);
        exp_addr = exp_rd ? base + 16'(2 * (k - 1)) : 16'h0;
        n_tests++;
        if (mem_read !== exp_rd || memory_address !== exp_addr) begin
          n_fail++;
          $display("FAIL issue base=%h k=%0d: mem_read=%b addr=%h, want %b %h",
                   base, k, mem_read, memory_address, exp_rd, exp_addr);
        end
        n_tests++;
        if (fsm_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL busy base=%h k=%0d: got %b, want 1", base, k, fsm_busy);
        end
        n_tests++;
        if (cur_vld) begin
          if (write_data_array !== 1'b1 || word_index !== 3'(nw) || write_tag_array !== (nw == 7)) begin
            n_fail++;
            $display("FAIL return base=%h word=%0d: wr=%b idx=%0d tag=%b, want 1 %0d %b",
                     base, nw, write_data_array, word_index, write_tag_array, nw, (nw == 7));
          end
          nw++;
          if (nw == 8) done = 1;
        end else if (write_data_array !== 1'b0 || write_tag_array !== 1'b0) begin
          n_fail++;
          $display("FAIL no_return base=%h k=%0d: wr=%b tag=%b, want 0 0",
                   base, k, write_data_array, write_tag_array);
        end
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout base=%h: only %0d words, want 8", base, nw);
    end
  endtask

  task automatic test_idle_quiet(input string tag, input int cycles, input logic stray);
    for (int i = 0; i < cycles; i++) begin
      tick(1'b0, 16'h0, stray);
      n_tests++;
      if (fsm_busy !== 1'b0 || mem_read !== 1'b0 || memory_address !== 16'h0 ||
          write_data_array !== 1'b0 || write_tag_array !== 1'b0 || word_index !== 3'd0) begin
        n_fail++;
        $display("FAIL %s idle %0d: busy=%b rd=%b addr=%h wr=%b tag=%b idx=%0d, want all 0",
                 tag, i, fsm_busy, mem_read, memory_address, write_data_array,
                 write_tag_array, word_index);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick(1'b0, 16'h0, 1'b0);
    test_idle_quiet("reset", 1, 1'b0);
    rst_n = 1'b1;
    test_idle_quiet("stray_valid", 3, 1'b1);
  endtask

  task automatic test_basic_fill();
    gap_fixed = 0; gap_rand = 0;
    run_fill(16'h1234, 0, 0);
    test_idle_quiet("after_basic", 2, 1'b1);
  endtask

  task automatic test_miss_during_fill();
    run_fill(16'h1234, 3, 0);
    test_idle_quiet("after_ignored_miss", 3, 1'b0);
  endtask

  task automatic test_reset_mid_fill();
    run_fill(16'h1234, 0, 3);
    rst_n = 1'b1;
    test_idle_quiet("after_reset", 6, 1'b0);
    run_fill(16'h0050, 0, 0);
  endtask

  task automatic test_top_of_memory();
    run_fill(16'hFFFA, 0, 0);
  endtask

  task automatic test_gaps();
    gap_fixed = 1;
    run_fill(16'h1234, 0, 0);
    gap_fixed = 0;
    test_idle_quiet("after_gaps", 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_fill(16'h2222, 0, 0);
    run_fill(16'h3338, 0, 0);
    test_idle_quiet("after_b2b", 1, 1'b0);
  endtask

  task automatic test_random();
    gap_rand = 3;
    for (int i = 0; i < 8; i++)
      run_fill(16'($urandom), int'($urandom_range(12)), 0);
    gap_rand = 0;
    test_idle_quiet("after_random", 2, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_miss_during_fill();
    test_reset_mid_fill();
    test_top_of_memory();
    test_gaps();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
